// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and
// buffers returned words in a small tagged prefetch queue feeding IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned QDEPTH    = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        valid
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   redirect_target;
    entry_t        q_mem [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] stale_left;
    logic [CW-1:0] discard_left;
    logic          q_valid;
    logic          pop;
    logic          credit_ok;
    logic          gnt;
    logic          rsp;
    logic          push;
    logic          unused_rpc;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_rpc      = ^redirect_pc[1:0];

    // Handshake qualifiers; a response with nothing outstanding is ignored.
    assign q_valid      = (count != '0);
    assign pop          = q_valid & ~stall & ~redirect;
    assign credit_ok    = (SW'(count) - SW'(pop) + SW'(outstanding)) < SW'(QDEPTH);
    assign gnt          = imem_req & imem_gnt;
    assign rsp          = imem_rvalid & (outstanding != '0);
    assign push         = rsp & (state == FETCH) & ~redirect;
    assign stale_left   = outstanding - CW'(rsp);
    assign discard_left = discard - CW'(rsp & (discard != '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (redirect && (stale_left != '0)) state_nxt = FLUSH;
            FLUSH:   if (discard_left == '0) state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        imem_req  = (state == FETCH) & credit_ok & ~redirect;
        imem_addr = pc;
        valid     = q_valid;
        instr     = NOP_INSTR;
        npc       = '0;
        if (q_valid) begin
            instr = q_mem[head].instr;
            npc   = q_mem[head].pc + 32'd4;
        end
    end

    // PC, response tag, in-flight counters and the prefetch queue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q_mem[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(gnt) - CW'(rsp);
            if (redirect) begin
                pc     <= redirect_target;
                rsp_pc <= redirect_target;
                head   <= '0;
                tail   <= '0;
                count  <= '0;
            end else begin
                if (gnt) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    q_mem[tail] <= {imem_rdata, rsp_pc};
                    tail        <= tail + PW'(1);
                    rsp_pc      <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
            // Responses still owed to the old stream are counted down in FLUSH.
            if ((state == FETCH) && redirect) begin
                discard <= stale_left;
            end else if (state == FLUSH) begin
                discard <= discard_left;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural instruction memory with variable latency,
// directed stimulus, and a scoreboard drained by an independent monitor.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;

    pend_t pend[$];
    exp_t  exp_q[$];
    exp_t  mon_e;
    int    cyc;
    int    lat;
    int    checks;
    int    errors;
    int    consumed;

    if_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .npc         (npc),
        .valid       (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One cycle: advance to the falling edge and present any due memory response.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (!reset) begin
            pend.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic push_stream(input logic [31:0] start);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            a = start + 32'(4 * i);
            exp_q.push_back('{mem_word(a), a + 32'd4});
        end
    endtask

    task automatic wait_rvalid(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (imem_rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic expect_drain(input string name, input int n, input int budget);
        int c0;
        bit ok;
        c0 = consumed;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (consumed - c0 >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Monitor: records grants for the memory model and scores every consumed entry.
    always begin
        @(negedge clock);
        #4;
        if (reset) begin
            if (imem_req && imem_gnt) begin
                pend.push_back('{imem_addr, cyc + lat});
            end
            if (valid && !stall && !redirect) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got npc %08h expected none", npc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_instr", instr, mon_e.instr);
                    chk("sb_npc", npc, mon_e.npc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        lat         = 1;
        cyc         = 0;
        checks      = 0;
        errors      = 0;
        consumed    = 0;

        // Reset state
        step();
        step();
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_npc", npc, 32'h0);

        // Reset release, streaming with 1-cycle latency
        push_stream(32'h0);
        step();
        reset = 1'b1;
        #1;
        chk("boot_req", 32'(imem_req), 32'd0);
        step();
        #1;
        chk("t1_req0", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        step();
        #1;
        chk("t1_addr1", imem_addr, 32'h4);
        step();
        #1;
        chk("t1_addr2", imem_addr, 32'h8);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_npc", npc, 32'h4);
        step();
        step();

        // Stall with a full queue: head held, no requests
        step();
        stall = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_instr", instr, exp_q[0].instr);
            chk("stall_npc", npc, exp_q[0].npc);
        end
        step();
        stall = 1'b0;
        #1;
        chk("resume_req", 32'(imem_req), 32'd1);
        step();
        #1;
        chk("resume_req2", 32'(imem_req), 32'd1);

        // Redirect + stall + rvalid together; unaligned target
        wait_rvalid("t4_rvalid_seen");
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        push_stream(32'h0000_0200);
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        chk("t4_valid", 32'(valid), 32'd0);
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h0000_0200);
        expect_drain("t4_drain", 3, 20);

        // PC wrap at the top of the address space
        wait_rvalid("t5_rvalid_seen");
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        push_stream(32'hFFFF_FFF8);
        step();
        redirect = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        #1;
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        #1;
        chk("wrap_addr2", imem_addr, 32'h0);
        expect_drain("t5_drain", 3, 20);

        // Redirect with two stale responses in flight
        lat = 3;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        push_stream(32'h0000_0040);
        step();
        redirect = 1'b0;
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (pend.size() == 2 && !imem_rvalid) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("t3_two_outstanding", 32'(found), 32'd1);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        push_stream(32'h0000_0100);
        step();
        redirect = 1'b0;
        #1;
        chk("t3_valid", 32'(valid), 32'd0);
        chk("t3_flush_req", 32'(imem_req), 32'd0);
        expect_drain("t3_drain", 2, 30);
        lat = 1;

        // Grant withheld: request and address must hold
        step();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        push_stream(32'h0000_0300);
        step();
        redirect = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            chk("nognt_req", 32'(imem_req), 32'd1);
            chk("nognt_addr", imem_addr, 32'h0000_0300);
        end
        imem_gnt = 1'b1;
        expect_drain("t6_drain", 2, 20);

        // Asynchronous reset mid-burst, checked before the next clock edge
        step();
        #2;
        reset = 1'b0;
        pend.delete();
        imem_rvalid = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_instr", instr, NOP);
        chk("arst_npc", npc, 32'h0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
